// File: rtl/axis_packet_snooper.sv
// Passive AXI-Stream snooper: packs PACK beats per memory word, writes complete packets to
// packet memory, truncates oversize packets and counts dropped/aborted packets.
module axis_packet_snooper #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PACK          = 2,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned ADDR_STEP     = 2,
    parameter int unsigned MAX_WORDS     = 512,
    parameter int unsigned LEN_WIDTH     = 16,
    parameter bit          SYNC_ON_RESET = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_WIDTH-1:0]        TDATA,
    input  logic [DATA_WIDTH/8-1:0]      TKEEP,
    input  logic                         TVALID,
    input  logic                         TREADY,
    input  logic                         TLAST,
    input  logic                         mem_ready,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [DATA_WIDTH*PACK-1:0]   wr_data,
    output logic                         wr_en,
    output logic                         done,
    output logic                         abort,
    output logic                         truncated,
    output logic [LEN_WIDTH-1:0]         byte_len,
    output logic [LEN_WIDTH-1:0]         drop_cnt
);

    localparam int unsigned KeepWidth = DATA_WIDTH / 8;
    localparam int unsigned WordWidth = DATA_WIDTH * PACK;
    localparam int unsigned LaneWidth = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned CntWidth  = $clog2(MAX_WORDS + 1);
    localparam int unsigned PopWidth  = $clog2(KeepWidth + 1);

    typedef enum logic [2:0] {StSync, StIdle, StCapture, StTrunc, StDrop} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LaneWidth-1:0]   lane_q, lane_d;
    logic [CntWidth-1:0]    words_q, words_d;
    logic [LEN_WIDTH-1:0]   bytes_q, bytes_d;
    logic [WordWidth-1:0]   word_q, word_d;

    logic [ADDR_WIDTH-1:0]  wr_addr_d;
    logic [WordWidth-1:0]   wr_data_d;
    logic                   wr_en_d, done_d, abort_d, truncated_d;
    logic [LEN_WIDTH-1:0]   byte_len_d, drop_cnt_d;

    logic                   beat;
    logic [DATA_WIDTH-1:0]  beat_data;
    logic [PopWidth-1:0]    keep_cnt;
    logic                   starting;
    logic [ADDR_WIDTH-1:0]  addr_base;
    logic [LaneWidth-1:0]   lane_base;
    logic [CntWidth-1:0]    words_base;
    logic [LEN_WIDTH-1:0]   bytes_base;
    logic [WordWidth-1:0]   word_base, word_next;
    logic [LEN_WIDTH:0]     byte_sum;
    logic [LEN_WIDTH-1:0]   bytes_next;

    assign beat = TVALID && TREADY;

    // Masked beat data, valid-byte count, and the word as it looks with this beat merged in.
    always_comb begin
        beat_data = '0;
        keep_cnt  = '0;
        for (int i = 0; i < KeepWidth; i++) begin
            beat_data[i*8 +: 8] = TKEEP[i] ? TDATA[i*8 +: 8] : 8'h00;
            keep_cnt            = keep_cnt + PopWidth'(TKEEP[i]);
        end

        // A capture launched from IDLE always starts from a clean slate.
        starting   = (state_q == StIdle);
        addr_base  = starting ? '0 : addr_q;
        lane_base  = starting ? '0 : lane_q;
        words_base = starting ? '0 : words_q;
        bytes_base = starting ? '0 : bytes_q;
        word_base  = starting ? '0 : word_q;

        word_next = word_base;
        for (int l = 0; l < PACK; l++) begin
            if (lane_base == LaneWidth'(l)) begin
                word_next[l*DATA_WIDTH +: DATA_WIDTH] = beat_data;
            end
        end

        byte_sum   = {1'b0, bytes_base} + (LEN_WIDTH + 1)'(keep_cnt);
        bytes_next = byte_sum[LEN_WIDTH] ? '1 : byte_sum[LEN_WIDTH-1:0];
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        words_d     = words_q;
        bytes_d     = bytes_q;
        word_d      = word_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        truncated_d = 1'b0;
        byte_len_d  = '0;
        drop_cnt_d  = drop_cnt;

        if (beat) begin
            case (state_q)
                StSync: begin
                    if (TLAST) state_d = StIdle;
                end
                StIdle, StCapture: begin
                    if (!mem_ready) begin
                        if (drop_cnt != '1) drop_cnt_d = drop_cnt + LEN_WIDTH'(1);
                        abort_d = (state_q == StCapture);
                        addr_d  = '0;
                        lane_d  = '0;
                        words_d = '0;
                        bytes_d = '0;
                        word_d  = '0;
                        state_d = TLAST ? StIdle : StDrop;
                    end else if (lane_base == LaneWidth'(PACK - 1) || TLAST) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_base;
                        wr_data_d = word_next;
                        word_d    = '0;
                        lane_d    = '0;
                        if (TLAST) begin
                            done_d     = 1'b1;
                            byte_len_d = bytes_next;
                            addr_d     = '0;
                            words_d    = '0;
                            bytes_d    = '0;
                            state_d    = StIdle;
                        end else begin
                            addr_d  = addr_base + ADDR_WIDTH'(ADDR_STEP);
                            words_d = words_base + CntWidth'(1);
                            bytes_d = bytes_next;
                            // Packet still running after its last permitted word.
                            state_d = (words_d == CntWidth'(MAX_WORDS)) ? StTrunc : StCapture;
                        end
                    end else begin
                        word_d  = word_next;
                        lane_d  = lane_base + LaneWidth'(1);
                        addr_d  = addr_base;
                        words_d = words_base;
                        bytes_d = bytes_next;
                        state_d = StCapture;
                    end
                end
                StTrunc: begin
                    if (TLAST) begin
                        done_d      = 1'b1;
                        truncated_d = 1'b1;
                        byte_len_d  = bytes_q;
                        addr_d      = '0;
                        lane_d      = '0;
                        words_d     = '0;
                        bytes_d     = '0;
                        word_d      = '0;
                        state_d     = StIdle;
                    end
                end
                StDrop: begin
                    if (TLAST) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SYNC_ON_RESET ? StSync : StIdle;
            addr_q    <= '0;
            lane_q    <= '0;
            words_q   <= '0;
            bytes_q   <= '0;
            word_q    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            abort     <= 1'b0;
            truncated <= 1'b0;
            byte_len  <= '0;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            words_q   <= words_d;
            bytes_q   <= bytes_d;
            word_q    <= word_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            done      <= done_d;
            abort     <= abort_d;
            truncated <= truncated_d;
            byte_len  <= byte_len_d;
            drop_cnt  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_packet_snooper.sv
// Scoreboard bench for axis_packet_snooper: default instance (SYNC_ON_RESET=1) and a
// MAX_WORDS=2 instance (SYNC_ON_RESET=0) share the bus; tvalid is steered by sel_b.
module tb_axis_packet_snooper;

    typedef struct packed {
        int unsigned cyc;
        logic        wr;
        logic [9:0]  addr;
        logic [63:0] data;
        logic        done;
        logic        abort;
        logic        trunc;
        logic [15:0] len;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] TDATA;
    logic [3:0]  TKEEP;
    logic        TVALID, TREADY, TLAST, mem_ready;
    logic        sel_b;
    logic        tvalid_a, tvalid_b;

    logic [9:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic        a_wr, b_wr, a_done, b_done, a_abort, b_abort, a_trunc, b_trunc;
    logic [15:0] a_len, b_len, a_drop, b_drop;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    evt_t        exp_a[$];
    evt_t        exp_b[$];

    assign tvalid_a = TVALID && !sel_b;
    assign tvalid_b = TVALID && sel_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_packet_snooper dut_a (
        .clk(clk), .rst_n(rst_n), .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(tvalid_a),
        .TREADY(TREADY), .TLAST(TLAST), .mem_ready(mem_ready), .wr_addr(a_addr),
        .wr_data(a_data), .wr_en(a_wr), .done(a_done), .abort(a_abort),
        .truncated(a_trunc), .byte_len(a_len), .drop_cnt(a_drop)
    );

    axis_packet_snooper #(.MAX_WORDS(2), .SYNC_ON_RESET(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(tvalid_b),
        .TREADY(TREADY), .TLAST(TLAST), .mem_ready(mem_ready), .wr_addr(b_addr),
        .wr_data(b_data), .wr_en(b_wr), .done(b_done), .abort(b_abort),
        .truncated(b_trunc), .byte_len(b_len), .drop_cnt(b_drop)
    );

    task automatic check_evt(input bit which, input evt_t act);
        evt_t e;
        checks++;
        if ((which ? exp_b.size() : exp_a.size()) == 0) begin
            errors++;
            $display("FAIL %s unexpected output: got cyc=%0d wr=%0b addr=%0h data=%h done=%0b abort=%0b, required none",
                     which ? "dut_b" : "dut_a", act.cyc, act.wr, act.addr, act.data, act.done, act.abort);
        end else begin
            e = which ? exp_b.pop_front() : exp_a.pop_front();
            if (act.cyc != e.cyc || act.wr != e.wr || act.done != e.done || act.abort != e.abort ||
                (e.wr && (act.addr != e.addr || act.data != e.data)) ||
                (e.done && (act.trunc != e.trunc || act.len != e.len))) begin
                errors++;
                $display("FAIL %s event: got cyc=%0d wr=%0b addr=%0h data=%h done=%0b abort=%0b trunc=%0b len=%0d, required cyc=%0d wr=%0b addr=%0h data=%h done=%0b abort=%0b trunc=%0b len=%0d",
                         which ? "dut_b" : "dut_a", act.cyc, act.wr, act.addr, act.data, act.done,
                         act.abort, act.trunc, act.len, e.cyc, e.wr, e.addr, e.data, e.done,
                         e.abort, e.trunc, e.len);
            end
        end
    endtask

    // Monitor: every cycle with any strobe up is one scoreboard event.
    always @(negedge clk) begin
        if (a_wr || a_done || a_abort)
            check_evt(1'b0, '{cyc, a_wr, a_addr, a_data, a_done, a_abort, a_trunc, a_len});
        if (b_wr || b_done || b_abort)
            check_evt(1'b1, '{cyc, b_wr, b_addr, b_data, b_done, b_abort, b_trunc, b_len});
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Expected output appears one cycle after the beat about to be issued.
    task automatic expect_evt(input bit which, input logic wr, input logic [9:0] addr,
                              input logic [63:0] data, input logic dn, input logic ab,
                              input logic tr, input logic [15:0] len);
        evt_t e;
        e = '{cyc + 1, wr, addr, data, dn, ab, tr, len};
        if (which) exp_b.push_back(e);
        else       exp_a.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic mr);
        TDATA = d; TKEEP = k; TLAST = l; mem_ready = mr; TVALID = 1'b1; TREADY = 1'b1;
        @(posedge clk); #1;
    endtask

    // Non-beat cycle carrying junk that must have no effect.
    task automatic gap(input logic v, input logic r);
        TDATA = 32'hDEAD_BEEF; TKEEP = 4'hF; TLAST = 1'b1; mem_ready = 1'b0;
        TVALID = v; TREADY = r;
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " wr_en"}, {63'd0, a_wr}, 64'd0);
        check_val({tag, " wr_addr"}, {54'd0, a_addr}, 64'd0);
        check_val({tag, " wr_data"}, a_data, 64'd0);
        check_val({tag, " done"}, {63'd0, a_done}, 64'd0);
        check_val({tag, " abort"}, {63'd0, a_abort}, 64'd0);
        check_val({tag, " truncated"}, {63'd0, a_trunc}, 64'd0);
        check_val({tag, " byte_len"}, {48'd0, a_len}, 64'd0);
        check_val({tag, " drop_cnt"}, {48'd0, a_drop}, 64'd0);
        check_val({tag, " dut_b drop_cnt"}, {48'd0, b_drop}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; sel_b = 1'b0;
        TDATA = '0; TKEEP = '0; TVALID = 1'b0; TREADY = 1'b0; TLAST = 1'b0; mem_ready = 1'b0;
        // Traffic already flowing while in reset.
        send(32'h0BAD_0000, 4'hF, 1'b0, 1'b1);
        send(32'h0BAD_0001, 4'hF, 1'b0, 1'b1);
        send(32'h0BAD_0002, 4'hF, 1'b0, 1'b1);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Tail of the in-flight packet is swallowed by the resync.
        send(32'h0BAD_0003, 4'hF, 1'b0, 1'b1);
        send(32'h0BAD_0004, 4'hF, 1'b0, 1'b1);
        send(32'h0BAD_0005, 4'hF, 1'b0, 1'b1);
        send(32'h0BAD_0006, 4'hF, 1'b1, 1'b1);

        // Four full beats.
        send(32'h1111_0000, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 1, 10'd0, 64'h1111_0001_1111_0000, 0, 0, 0, 16'd0);
        send(32'h1111_0001, 4'hF, 1'b0, 1'b1);
        send(32'h1111_0002, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 1, 10'd2, 64'h1111_0003_1111_0002, 1, 0, 0, 16'd16);
        send(32'h1111_0003, 4'hF, 1'b1, 1'b1);

        // Back-to-back three-beat packet with partial last beat.
        send(32'h2222_0000, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 1, 10'd0, 64'h2222_0001_2222_0000, 0, 0, 0, 16'd0);
        send(32'h2222_0001, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 1, 10'd2, 64'h0000_0000_0000_DDDD, 1, 0, 0, 16'd10);
        send(32'hCCCC_DDDD, 4'b0011, 1'b1, 1'b1);
        gap(1'b0, 1'b0);

        // Dropped at the first beat.
        send(32'h3333_0000, 4'hF, 1'b0, 1'b0);
        send(32'h3333_0001, 4'hF, 1'b0, 1'b1);
        send(32'h3333_0002, 4'hF, 1'b1, 1'b1);
        check_val("drop_cnt after drop", {48'd0, a_drop}, 64'd1);
        send(32'h4444_0000, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 1, 10'd0, 64'h4444_0001_4444_0000, 1, 0, 0, 16'd8);
        send(32'h4444_0001, 4'hF, 1'b1, 1'b1);

        // mem_ready falls on beat 3 of 6.
        send(32'h5555_0000, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 1, 10'd0, 64'h5555_0001_5555_0000, 0, 0, 0, 16'd0);
        send(32'h5555_0001, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 0, 10'd0, 64'd0, 0, 1, 0, 16'd0);
        send(32'h5555_0002, 4'hF, 1'b0, 1'b0);
        send(32'h5555_0003, 4'hF, 1'b0, 1'b1);
        send(32'h5555_0004, 4'hF, 1'b0, 1'b1);
        send(32'h5555_0005, 4'hF, 1'b1, 1'b1);
        check_val("drop_cnt after abort", {48'd0, a_drop}, 64'd2);

        // Stalls and idles interleaved.
        send(32'h6666_0000, 4'hF, 1'b0, 1'b1);
        gap(1'b1, 1'b0);
        gap(1'b0, 1'b1);
        expect_evt(0, 1, 10'd0, 64'h6666_0001_6666_0000, 0, 0, 0, 16'd0);
        send(32'h6666_0001, 4'hF, 1'b0, 1'b1);
        gap(1'b1, 1'b0);
        send(32'h6666_0002, 4'hF, 1'b0, 1'b1);
        gap(1'b1, 1'b0);
        gap(1'b1, 1'b0);
        expect_evt(0, 1, 10'd2, 64'h6666_0003_6666_0002, 1, 0, 0, 16'd16);
        send(32'h6666_0003, 4'hF, 1'b1, 1'b1);
        gap(1'b0, 1'b0);

        // MAX_WORDS=2 instance: truncation, exact fit, single partial beat.
        sel_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) expect_evt(1, 1, 10'd0, 64'h7777_0001_7777_0000, 0, 0, 0, 16'd0);
            if (i == 3) expect_evt(1, 1, 10'd2, 64'h7777_0003_7777_0002, 0, 0, 0, 16'd0);
            if (i == 7) expect_evt(1, 0, 10'd0, 64'd0, 1, 0, 1, 16'd16);
            send(32'h7777_0000 + 32'(i), 4'hF, i == 7, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) expect_evt(1, 1, 10'd0, 64'h8888_0001_8888_0000, 0, 0, 0, 16'd0);
            if (i == 3) expect_evt(1, 1, 10'd2, 64'h8888_0003_8888_0002, 1, 0, 0, 16'd16);
            send(32'h8888_0000 + 32'(i), 4'hF, i == 3, 1'b1);
        end
        expect_evt(1, 1, 10'd0, 64'h0000_0000_0099_0000, 1, 0, 0, 16'd3);
        send(32'h9999_0000, 4'b0111, 1'b1, 1'b1);
        gap(1'b0, 1'b0);
        sel_b = 1'b0;
        check_val("dut_b drop_cnt", {48'd0, b_drop}, 64'd0);

        // Reset while a write is on the outputs.
        send(32'hAAAA_0000, 4'hF, 1'b0, 1'b1);
        expect_evt(0, 1, 10'd0, 64'hAAAA_0001_AAAA_0000, 0, 0, 0, 16'd0);
        send(32'hAAAA_0001, 4'hF, 1'b0, 1'b1);
        rst_n = 1'b0;
        gap(1'b0, 1'b0);
        check_all_zero("mid-capture reset");
        rst_n = 1'b1;
        send(32'hBBBB_0000, 4'hF, 1'b1, 1'b1);
        expect_evt(0, 1, 10'd0, 64'h0000_0000_CCCC_1234, 1, 0, 0, 16'd4);
        send(32'hCCCC_1234, 4'hF, 1'b1, 1'b1);
        gap(1'b0, 1'b0);
        gap(1'b0, 1'b0);
        gap(1'b0, 1'b0);

        check_val("dut_a outstanding events", 64'(exp_a.size()), 64'd0);
        check_val("dut_b outstanding events", 64'(exp_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_packet_snooper.md
# axis_packet_snooper

Parametrised passive AXI-Stream snooper that copies complete packets from a monitored stream into packet memory. It packs PACK consecutive bus beats into one memory word, counts valid bytes via TKEEP, truncates oversize packets, and reports dropped and aborted packets instead of silently corrupting memory. It sits between a monitored AXI-Stream link and the packet-memory write port, feeding the BPF filter pipeline.

## Interface
- DATA_WIDTH, 32: snooped TDATA width in bits; multiple of 8.
- PACK, 2: beats per memory word; memory word width is DATA_WIDTH*PACK.
- ADDR_WIDTH, 10: packet-memory address width.
- ADDR_STEP, 2: address increment per memory word.
- MAX_WORDS, 512: memory words per packet before truncation; at most 2**ADDR_WIDTH/ADDR_STEP.
- LEN_WIDTH, 16: width of byte_len and drop_cnt.
- SYNC_ON_RESET, 1: 1 = after reset, discard traffic up to and including the first TLAST beat.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- TDATA  in  DATA_WIDTH  snooped data.
- TKEEP  in  DATA_WIDTH/8  snooped byte enables; contiguous from bit 0.
- TVALID  in  1  snooped valid.
- TREADY  in  1  snooped ready (input; block never drives the bus).
- TLAST  in  1  snooped end of packet.
- mem_ready  in  1  packet memory can accept the current packet.
- wr_addr  out  ADDR_WIDTH  memory word address.
- wr_data  out  DATA_WIDTH*PACK  packed memory word.
- wr_en  out  1  write strobe.
- done  out  1  one-cycle pulse: packet complete.
- abort  out  1  one-cycle pulse: packet abandoned mid-capture.
- truncated  out  1  valid with done: packet exceeded MAX_WORDS.
- byte_len  out  LEN_WIDTH  valid with done: bytes written.
- drop_cnt  out  LEN_WIDTH  saturating count of packets dropped or aborted.

## Operation
- Beat = TVALID && TREADY. No other input combination has any effect.
- States: SYNC, IDLE, CAPTURE, TRUNC, DROP. Reset enters SYNC if SYNC_ON_RESET=1, otherwise IDLE.
- SYNC: beats are ignored. A beat with TLAST moves to IDLE.
- IDLE: a beat with mem_ready=1 starts capture at address 0 in lane 0. If that beat also has TLAST, it is a single-beat packet and the state stays IDLE; otherwise go to CAPTURE. A beat with mem_ready=0 increments drop_cnt and goes to DROP, or stays in IDLE if the beat has TLAST.
- CAPTURE: each beat fills the next lane; lane 0 occupies the LSBs. mem_ready is sampled on every beat. A beat with mem_ready=0 produces no write, pulses abort, increments drop_cnt, resets the address to 0, and goes to DROP (IDLE if TLAST).
- Word emit: when lane PACK-1 fills, or on TLAST, the assembled word is written. Unfilled lanes and bytes with TKEEP=0 are written as zero. The address advances by ADDR_STEP after each write.
- Byte count: byte_len accumulates popcount(TKEEP) of written beats and saturates at all-ones.
- Truncation: after the MAX_WORDS-th write, further non-TLAST beats go to TRUNC, where they are discarded. The TLAST beat pulses done with truncated=1 and wr_en=0.
- DROP: discards beats until a TLAST beat, then goes to IDLE.
- On done or abort, the address, lane index and byte counter clear for the next packet.
- drop_cnt saturates and clears only on reset.

## Timing
- Reset (rst_n=0 at a clock edge) clears all outputs to 0 and drop_cnt to 0. A reset mid-packet discards that packet with no done/abort pulse; re-entry follows SYNC_ON_RESET.
- Outputs are registered. wr_en/wr_addr/wr_data appear exactly 1 cycle after the beat that completes the word.
- done is asserted in the same cycle as the final wr_en. In the truncated case, done is asserted 1 cycle after the TLAST beat.
- byte_len and truncated are valid only while done=1.
- abort is asserted 1 cycle after the offending beat.
- Back-to-back packets (TLAST followed immediately by a new first beat) are captured with no gap.
- Maximum write rate is one word per PACK beats, or one per cycle on TLAST.

## Test plan
- SYNC_ON_RESET=1: release reset mid-packet, 3 beats then TLAST -> no writes. Next packet of 4 full beats -> writes at addr 0 and 2, done with the second write, byte_len=16.
- 3-beat packet, last TKEEP=4'b0011 -> writes {B1,B0} at addr 0 and {0,B2 with upper 2 bytes zero} at addr 2; done; byte_len=10.
- First beat with mem_ready=0 -> no writes for the whole packet, drop_cnt=1, next packet captured at address 0.
- mem_ready drops on beat 3 of 6 -> one write at addr 0, abort pulse 1 cycle later, drop_cnt=1, no done.
- MAX_WORDS=2, 8-beat packet -> writes at addr 0 and 2 only; done 1 cycle after TLAST with truncated=1, byte_len=16.
- Beats with TVALID=1 and TREADY=0 interleaved with valid beats -> writes identical to the no-stall case, delayed accordingly. rst_n asserted mid-capture -> all outputs 0 on the next cycle.
